// File: rtl/capture_sequencer.sv
// Capture controller: arms the trigger, keeps a sliding pre-trigger window in the sample FIFO,
// fills the FIFO after the trigger, then hands the read port to the UART readout. Macro: CAPTURE_SEQ_AUTOREARM_EN.
module capture_sequencer #(
  parameter int DEPTH_W    = 10,
  parameter int CLR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [DEPTH_W-1:0] pretrig_cnt,
  input  logic               trig_hit,
  input  logic               FIFO_wrfull,
  input  logic               ctrl_rdreq,
  input  logic               readout_done,
  output logic               FIFO_wrreq,
  output logic               FIFO_rdreq,
  output logic               FIFO_aclr,
  output logic               triggerBlock_Syncrst,
  output logic               readout_start,
  output logic               busy,
  output logic [2:0]         state_debug
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_PRETRIG   = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_POST      = 3'd4,
    S_START_RD  = 3'd5,
    S_READOUT   = 3'd6
  } state_t;

  localparam int                CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t               r_state;
  logic [DEPTH_W-1:0]   r_pt_reg;
  logic [DEPTH_W-1:0]   r_wcnt;
  logic [CLR_W-1:0]     r_clr_cnt;

  logic [DEPTH_W-1:0]   w_pt_last;
  logic                 w_pt_nonzero;
  logic                 w_post_wr;

  assign w_pt_last    = r_pt_reg - 1'b1;
  assign w_pt_nonzero = (r_pt_reg != '0);
  // POST write is gated by the full flag directly so the FIFO is never written while full.
  assign w_post_wr    = (r_state == S_POST) && !FIFO_wrfull;

  // NOTE: every register in this block uses non-blocking assignment so all next-state
  // terms see the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pt_reg  <= '0;
      r_wcnt    <= '0;
      r_clr_cnt <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_pt_reg  <= pretrig_cnt;
            r_clr_cnt <= '0;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_wcnt <= '0;
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= w_pt_nonzero ? S_PRETRIG : S_WAIT_TRIG;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_PRETRIG: begin
          r_wcnt <= r_wcnt + 1'b1;
          // A window as large as the FIFO fills before the count ends; skip the trigger.
          if (FIFO_wrfull) begin
            r_state <= S_START_RD;
          end else if (r_wcnt == w_pt_last) begin
            r_state <= S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_hit) begin
            r_state <= S_POST;
          end
        end
        S_POST: begin
          if (w_post_wr) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
          if (FIFO_wrfull) begin
            r_state <= S_START_RD;
          end
        end
        S_START_RD: begin
          r_state <= S_READOUT;
        end
        S_READOUT: begin
          if (readout_done) begin
`ifdef CAPTURE_SEQ_AUTOREARM_EN
            r_clr_cnt <= '0;
            r_state   <= S_CLEAR;
`else
            r_state   <= S_IDLE;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign FIFO_wrreq           = (r_state == S_PRETRIG) || (r_state == S_WAIT_TRIG) || w_post_wr;
  assign FIFO_rdreq           = ((r_state == S_WAIT_TRIG) && w_pt_nonzero) ||
                                ((r_state == S_READOUT) && ctrl_rdreq);
  assign FIFO_aclr            = (r_state == S_CLEAR);
  assign triggerBlock_Syncrst = (r_state == S_CLEAR);
  assign readout_start        = (r_state == S_START_RD);
  assign busy                 = (r_state != S_IDLE);
  assign state_debug          = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: FIFO occupancy model, expected state-sequence scoreboard,
// per-state event counters checked against hand-derived totals.
module tb_capture_sequencer;

  localparam int DW    = 5;
  localparam int DEPTH = 32;
  localparam int CLR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] pretrig_cnt = '0;
  logic          trig_hit = 1'b0;
  logic          FIFO_wrfull;
  logic          ctrl_rdreq = 1'b0;
  logic          readout_done = 1'b0;
  logic          FIFO_wrreq, FIFO_rdreq, FIFO_aclr, triggerBlock_Syncrst;
  logic          readout_start, busy;
  logic [2:0]    state_debug;

  capture_sequencer #(.DEPTH_W(DW), .CLR_CYCLES(CLR)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .arm                  (arm),
    .abort                (abort),
    .pretrig_cnt          (pretrig_cnt),
    .trig_hit             (trig_hit),
    .FIFO_wrfull          (FIFO_wrfull),
    .ctrl_rdreq           (ctrl_rdreq),
    .readout_done         (readout_done),
    .FIFO_wrreq           (FIFO_wrreq),
    .FIFO_rdreq           (FIFO_rdreq),
    .FIFO_aclr            (FIFO_aclr),
    .triggerBlock_Syncrst (triggerBlock_Syncrst),
    .readout_start        (readout_start),
    .busy                 (busy),
    .state_debug          (state_debug)
  );

  always #5 clk = ~clk;

  // Sample FIFO occupancy model
  int occ = 0;
  always @(posedge clk) begin
    if (FIFO_aclr) occ <= 0;
    else occ <= occ + int'(FIFO_wrreq && !FIFO_wrfull) - int'(FIFO_rdreq && (occ > 0));
  end
  assign FIFO_wrfull = (occ >= DEPTH);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int aclr;
    int aclr_mis;
    int pre_wr;
    int wait_cyc;
    int wait_bad;
    int post_wr;
    int post_full_wr;
    int start;
    int rd_stray;
    int ro_rd;
    int busy_bad;
  } cnt_t;

  cnt_t cnt = '{default: 0};
  int   exp_q[$];
  bit   mon_en = 1'b0;
  int   cur_pt = 0;
  int   prev_state = 0;

  // Monitor: pops the expected next state on every state change, accumulates event counts.
  always @(negedge clk) begin
    int s;
    s = int'(state_debug);
    if (mon_en && (s != prev_state)) begin
      if (exp_q.size() == 0) check("sb_extra_state", s, -1);
      else check("state_seq", s, exp_q.pop_front());
    end
    prev_state = s;
    cnt.aclr         += int'(FIFO_aclr && triggerBlock_Syncrst);
    cnt.aclr_mis     += int'(FIFO_aclr != triggerBlock_Syncrst);
    cnt.pre_wr       += int'((s == 2) && FIFO_wrreq);
    cnt.wait_cyc     += int'(s == 3);
    cnt.wait_bad     += int'((s == 3) && !(FIFO_wrreq && (FIFO_rdreq == (cur_pt != 0))));
    cnt.post_wr      += int'((s == 4) && FIFO_wrreq);
    cnt.post_full_wr += int'((s == 4) && FIFO_wrreq && FIFO_wrfull);
    cnt.start        += int'(readout_start);
    cnt.rd_stray     += int'(FIFO_rdreq && (s != 3) && (s != 6));
    cnt.ro_rd        += int'((s == 6) && FIFO_rdreq);
    cnt.busy_bad     += int'(busy != (s != 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input bit tog);
    for (int i = 0; i < budget; i++) begin
      if (int'(state_debug) == s) return;
      if (tog) ctrl_rdreq = ~ctrl_rdreq;
      step();
    end
    check("wait_state_timeout", int'(state_debug), s);
  endtask

  task automatic arm_it(input int pt);
    cur_pt      = pt;
    pretrig_cnt = DW'(pt);
    arm         = 1'b1;
    step();
    arm         = 1'b0;
  endtask

  task automatic do_readout(input int n);
    wait_state(6, 50, 1'b0);
    for (int i = 0; i < n; i++) begin
      ctrl_rdreq = 1'b1;
      step();
    end
    ctrl_rdreq = 1'b0;
    check("occ_drained", occ, 0);
  endtask

  task automatic end_capture();
    cnt_t b;
    readout_done = 1'b1;
`ifdef CAPTURE_SEQ_AUTOREARM_EN
    exp_q.push_back(1);
    exp_q.push_back((cur_pt != 0) ? 2 : 3);
    exp_q.push_back(0);
`else
    exp_q.push_back(0);
`endif
    b = cnt;
    step();
    readout_done = 1'b0;
`ifdef CAPTURE_SEQ_AUTOREARM_EN
    check("rearm_clear", int'(state_debug), 1);
    wait_state((cur_pt != 0) ? 2 : 3, 50, 1'b0);
    check("rearm_aclr_cycles", cnt.aclr - b.aclr, CLR);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif
    step();
    check("idle_after_done", int'(state_debug), 0);
    check("busy_idle", int'(busy), 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cnt_t b;

    // Reset state
    step();
    check("rst_state", int'(state_debug), 0);
    check("rst_wrreq", int'(FIFO_wrreq), 0);
    check("rst_rdreq", int'(FIFO_rdreq), 0);
    check("rst_aclr", int'(FIFO_aclr), 0);
    check("rst_syncrst", int'(triggerBlock_Syncrst), 0);
    check("rst_start", int'(readout_start), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    step();
    mon_en = 1'b1;

    // pretrig 8, trigger 20 cycles after arm
    b = cnt;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
    arm_it(8);
    repeat (19) step();
    check("t2_in_wait", int'(state_debug), 3);
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    check("t2_post", int'(state_debug), 4);
    wait_state(5, 100, 1'b0);
    check("t2_full", occ, DEPTH);
    check("t2_aclr", cnt.aclr - b.aclr, CLR);
    check("t2_aclr_match", cnt.aclr_mis - b.aclr_mis, 0);
    check("t2_pre_wr", cnt.pre_wr - b.pre_wr, 8);
    check("t2_wait_cyc", cnt.wait_cyc - b.wait_cyc, 8);
    check("t2_wait_rw", cnt.wait_bad - b.wait_bad, 0);
    check("t2_post_wr", cnt.post_wr - b.post_wr, DEPTH - 8);
    check("t2_post_full_wr", cnt.post_full_wr - b.post_full_wr, 0);
    do_readout(DEPTH);
    check("t2_start_pulse", cnt.start - b.start, 1);
    check("t2_ro_rd", cnt.ro_rd - b.ro_rd, DEPTH);
    check("t2_rd_stray", cnt.rd_stray - b.rd_stray, 0);
    end_capture();

    // pretrig 0: CLEAR straight to WAIT_TRIG, no reads before readout
    b = cnt;
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(4);
    exp_q.push_back(5); exp_q.push_back(6);
    arm_it(0);
    wait_state(3, 50, 1'b0);
    check("t3_aclr", cnt.aclr - b.aclr, CLR);
    repeat (5) step();
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    wait_state(5, 100, 1'b0);
    check("t3_pre_wr", cnt.pre_wr - b.pre_wr, 0);
    check("t3_wait_cyc", cnt.wait_cyc - b.wait_cyc, 6);
    check("t3_wait_no_rd", cnt.wait_bad - b.wait_bad, 0);
    check("t3_post_wr", cnt.post_wr - b.post_wr, DEPTH - 6);
    check("t3_rd_stray", cnt.rd_stray - b.rd_stray, 0);
    check("t3_full", occ, DEPTH);
    do_readout(DEPTH);
    end_capture();

    // pretrig 5, trig_hit held high, ctrl_rdreq toggling before readout
    b = cnt;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
    trig_hit = 1'b1;
    arm_it(5);
    wait_state(4, 100, 1'b1);
    trig_hit = 1'b0;
    check("t4_pre_wr", cnt.pre_wr - b.pre_wr, 5);
    check("t4_wait_cyc", cnt.wait_cyc - b.wait_cyc, 1);
    check("t4_wait_rw", cnt.wait_bad - b.wait_bad, 0);
    wait_state(5, 100, 1'b1);
    ctrl_rdreq = 1'b0;
    check("t4_rd_stray", cnt.rd_stray - b.rd_stray, 0);
    check("t4_post_wr", cnt.post_wr - b.post_wr, DEPTH - 5);
    do_readout(DEPTH);
    end_capture();

    // abort together with trig_hit in WAIT_TRIG
    b = cnt;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    arm_it(3);
    wait_state(3, 50, 1'b0);
    abort    = 1'b1;
    trig_hit = 1'b1;
    step();
    abort    = 1'b0;
    trig_hit = 1'b0;
    check("t5_idle", int'(state_debug), 0);
    check("t5_busy", int'(busy), 0);
    repeat (3) step();
    check("t5_no_start", cnt.start - b.start, 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // asynchronous reset in the middle of POST
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    arm_it(2);
    wait_state(3, 50, 1'b0);
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    step();
    check("t1_in_post", int'(state_debug), 4);
    check("t1_post_wrreq", int'(FIFO_wrreq), 1);
    check("t1_sb_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t1_async_state", int'(state_debug), 0);
    check("t1_async_wrreq", int'(FIFO_wrreq), 0);
    check("t1_async_rdreq", int'(FIFO_rdreq), 0);
    check("t1_async_aclr", int'(FIFO_aclr), 0);
    check("t1_async_syncrst", int'(triggerBlock_Syncrst), 0);
    check("t1_async_start", int'(readout_start), 0);
    check("t1_async_busy", int'(busy), 0);
    step();
    rst = 1'b1;
    step();
    check("t1_stays_idle", int'(state_debug), 0);
    check("busy_decode", cnt.busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
